eth_pcs_scrambler_pipe: RTL and testbench

Parametrised successor to the 10GBASE-R self-synchronous scrambler/descrambler. Polynomial is G(x)=1+x^39+x^58.
- Supports 16/32/64-bit datapaths and a valid qualifier.
- Per-beat bypass for 66b sync headers and control beats.
- Seed load and registered outputs.
- In descrambler mode, a lock indicator flags when the 58-bit history is fully refilled.
- Sits between the 64b/66b encoder/decoder and the gearbox in the PCS TX/RX paths.

---
 rtl/eth_pcs_scrambler_pipe.sv | 111 +++++++++++
 tb/tb_eth_pcs_scrambler_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pcs_scrambler_pipe.sv
// eth_pcs_scrambler_pipe
// Self-synchronous scrambler/descrambler, G(x) = 1 + x^39 + x^58, for the
// 10GBASE-R PCS between the 64b/66b codec and the gearbox.
// All W_DATA bits are unrolled per cycle; bit 0 is the first bit on the line.
// Output is registered (1-cycle latency).
// Optional feature macro: ETH_PCS_SCR_ERR_INJ_EN adds i_err_inj, which flips
// o_data[0] of a valid, non-bypass beat after scrambling.
module eth_pcs_scrambler_pipe #(
   parameter int          W_DATA   = 32,
   parameter int          SCR_MODE = 0,
   parameter logic [57:0] P_SEED   = 58'h3FF_FFFF_FFFF_FFFF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic              i_bypass,
   input  logic              i_seed_load,
`ifdef ETH_PCS_SCR_ERR_INJ_EN
   input  logic              i_err_inj,
`endif
   input  logic [W_DATA-1:0] i_data,
   output logic              o_valid,
   output logic [W_DATA-1:0] o_data,
   output logic              o_locked
);

   // Beats needed to refill the 58-bit history in descrambler mode.
   localparam int          LOCK_BEATS = (58 + W_DATA - 1) / W_DATA;
   localparam logic [2:0]  LOCK_MAX   = 3'(LOCK_BEATS);

   if (!(W_DATA == 16 || W_DATA == 32 || W_DATA == 64)) begin : g_bad_width
      $error("eth_pcs_scrambler_pipe: W_DATA must be 16, 32 or 64");
   end
   if (!(SCR_MODE == 0 || SCR_MODE == 1)) begin : g_bad_mode
      $error("eth_pcs_scrambler_pipe: SCR_MODE must be 0 or 1");
   end

   logic [57:0]       r_lfsr;
   logic [2:0]        r_lock_cnt;
   logic              r_valid_p1;
   logic [W_DATA-1:0] r_data_p1;
   logic              r_locked_p1;

   logic [57:0]       w_next_lfsr;
   logic [W_DATA-1:0] w_scr;
   logic [W_DATA-1:0] w_out;

   // Lock counter saturates once the history has been fully refilled.
   function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
      return (cnt == LOCK_MAX) ? cnt : cnt + 3'd1;
   endfunction

   // Unrolled bit-serial recurrence: S[0] holds the most recent line bit.
   always_comb begin
      w_next_lfsr = r_lfsr;
      w_scr       = '0;
      for (int k = 0; k < W_DATA; k++) begin
         w_scr[k]    = i_data[k] ^ w_next_lfsr[38] ^ w_next_lfsr[57];
         w_next_lfsr = {w_next_lfsr[56:0], (SCR_MODE == 0) ? w_scr[k] : i_data[k]};
      end
   end

   // Optional bit-0 corruption; the LFSR still advances on the clean result.
`ifdef ETH_PCS_SCR_ERR_INJ_EN
   always_comb begin
      w_out = w_scr ^ {{(W_DATA-1){1'b0}}, i_err_inj};
   end
`else
   always_comb begin
      w_out = w_scr;
   end
`endif

   // LFSR and lock counter: seed load wins over the beat update; bypass freezes both.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_lfsr     <= P_SEED;
         r_lock_cnt <= 3'd0;
      end else if (i_seed_load) begin
         r_lfsr     <= P_SEED;
         r_lock_cnt <= 3'd0;
      end else if (i_valid && !i_bypass) begin
         r_lfsr     <= w_next_lfsr;
         r_lock_cnt <= sat_inc(r_lock_cnt);
      end
   end

   // ---- stage p1: registered output beat, qualifier and lock flag ----
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_valid_p1  <= 1'b0;
         r_data_p1   <= '0;
         r_locked_p1 <= 1'b0;
      end else begin
         r_valid_p1 <= i_valid;
         if (i_valid) begin
            r_data_p1 <= i_bypass ? i_data : w_out;
         end
         if (SCR_MODE == 0) begin
            r_locked_p1 <= 1'b1;
         end else if (i_valid) begin
            r_locked_p1 <= (r_lock_cnt == LOCK_MAX);
         end
      end
   end

   assign o_valid  = r_valid_p1;
   assign o_data   = r_data_p1;
   assign o_locked = r_locked_p1;

endmodule

// File: tb/tb_eth_pcs_scrambler_pipe.sv
// Bench for eth_pcs_scrambler_pipe: scrambler W32, scrambler->descrambler
// loopback W64, descrambler W16. Reference model works on the line bit stream
// directly: out[n] = in[n] ^ line[n-39] ^ line[n-58], line primed with seed ones.
module tb_eth_pcs_scrambler_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // scrambler W32
   logic        a_rst, a_valid, a_byp, a_seed;
   logic [31:0] a_data, a_od;
   logic        a_ov, a_ol;
   // loopback W64: scrambler b feeds descrambler c
   logic        b_rst, b_valid;
   logic [63:0] b_data, b_od, c_od;
   logic        b_ov, b_ol, c_ov, c_ol;
   // descrambler W16
   logic        d_rst, d_valid, d_byp, d_seed;
   logic [15:0] d_data, d_od;
   logic        d_ov, d_ol;

   eth_pcs_scrambler_pipe #(.W_DATA(32), .SCR_MODE(0)) u_scr32 (
      .i_clk(clk), .i_reset(a_rst), .i_valid(a_valid), .i_bypass(a_byp),
      .i_seed_load(a_seed),
`ifdef ETH_PCS_SCR_ERR_INJ_EN
      .i_err_inj(1'b0),
`endif
      .i_data(a_data), .o_valid(a_ov), .o_data(a_od), .o_locked(a_ol));

   eth_pcs_scrambler_pipe #(.W_DATA(64), .SCR_MODE(0)) u_scr64 (
      .i_clk(clk), .i_reset(b_rst), .i_valid(b_valid), .i_bypass(1'b0),
      .i_seed_load(1'b0),
`ifdef ETH_PCS_SCR_ERR_INJ_EN
      .i_err_inj(1'b0),
`endif
      .i_data(b_data), .o_valid(b_ov), .o_data(b_od), .o_locked(b_ol));

   eth_pcs_scrambler_pipe #(.W_DATA(64), .SCR_MODE(1)) u_dsc64 (
      .i_clk(clk), .i_reset(b_rst), .i_valid(b_ov), .i_bypass(1'b0),
      .i_seed_load(1'b0),
`ifdef ETH_PCS_SCR_ERR_INJ_EN
      .i_err_inj(1'b0),
`endif
      .i_data(b_od), .o_valid(c_ov), .o_data(c_od), .o_locked(c_ol));

   eth_pcs_scrambler_pipe #(.W_DATA(16), .SCR_MODE(1)) u_dsc16 (
      .i_clk(clk), .i_reset(d_rst), .i_valid(d_valid), .i_bypass(d_byp),
      .i_seed_load(d_seed),
`ifdef ETH_PCS_SCR_ERR_INJ_EN
      .i_err_inj(1'b0),
`endif
      .i_data(d_data), .o_valid(d_ov), .o_data(d_od), .o_locked(d_ol));

   // Line history per model: entries 0..57 are the seed, entry 58+n is line bit n.
   bit m_line [0:2][0:65600];
   int m_pos  [0:2];

   task automatic model_reset(input int id);
      m_pos[id] = 0;
      for (int i = 0; i < 58; i++) m_line[id][i] = 1'b1;
   endtask

   task automatic ref_beat(input int id, input int w, input bit descr,
                           input logic [63:0] d, output logic [63:0] o);
      int n;
      bit ob;
      o = '0;
      for (int k = 0; k < w; k++) begin
         n  = m_pos[id];
         ob = d[k] ^ m_line[id][n + 19] ^ m_line[id][n];
         o[k] = ob;
         m_line[id][n + 58] = descr ? d[k] : ob;
         m_pos[id] = n + 1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] e, e2, last;
      logic [63:0] orig_q[$];
      logic [15:0] x;
      int          d_cnt;
      bit          exp_lock;

      for (int id = 0; id < 3; id++) model_reset(id);
      a_rst = 0; a_valid = 0; a_byp = 0; a_seed = 0; a_data = '0;
      b_rst = 0; b_valid = 0; b_data = '0;
      d_rst = 0; d_valid = 0; d_byp = 0; d_seed = 0; d_data = '0;
      tick(); tick();
      chk("rst_a_valid",  a_ov, 0);
      chk("rst_a_data",   a_od, 0);
      chk("rst_a_locked", a_ol, 0);
      chk("rst_c_locked", c_ol, 0);
      chk("rst_d_data",   d_od, 0);
      chk("rst_d_locked", d_ol, 0);

      a_rst = 1; b_rst = 1; d_rst = 1;
      tick();
      chk("scr_locked_after_release", a_ol, 1);
      chk("dsc_unlocked_after_release", d_ol, 0);

      // ---- scrambler W32: golden zero beats ----
      a_valid = 1; a_data = 32'h0;
      ref_beat(0, 32, 0, 64'(a_data), e);
      tick();
      chk("a_gold0_valid", a_ov, 1);
      chk("a_gold0", a_od, 32'h0000_0000);
      chk("a_gold0_model", a_od, e);
      ref_beat(0, 32, 0, 64'(a_data), e);
      tick();
      chk("a_gold1", a_od, 32'h03FF_FF80);
      chk("a_gold1_model", a_od, e);

      // random stream with a bypass beat in the middle
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            a_byp = 1; a_data = 32'hDEAD_BEEF; e = 64'h0000_0000_DEAD_BEEF;
         end else begin
            a_byp = 0; a_data = $urandom;
            ref_beat(0, 32, 0, 64'(a_data), e);
         end
         tick();
         chk((i == 4) ? "a_bypass" : "a_rand", a_od, e);
      end
      a_byp = 0;

      // idle beat: output holds, LFSR holds
      last = e;
      a_valid = 0; a_data = $urandom;
      tick();
      chk("a_idle_valid", a_ov, 0);
      chk("a_idle_hold", a_od, last);
      a_valid = 1; a_data = $urandom;
      ref_beat(0, 32, 0, 64'(a_data), e);
      tick();
      chk("a_after_idle", a_od, e);

      // seed load with a valid beat: beat uses old state, next restarts
      a_seed = 1; a_data = $urandom;
      ref_beat(0, 32, 0, 64'(a_data), e);
      model_reset(0);
      tick();
      chk("a_seed_same_beat", a_od, e);
      a_seed = 0; a_data = 32'h0;
      tick();
      chk("a_seed_next0", a_od, 32'h0000_0000);
      tick();
      chk("a_seed_next1", a_od, 32'h03FF_FF80);

      // seed load alone (no valid) still reloads
      a_valid = 0; a_seed = 1;
      tick();
      a_seed = 0; a_valid = 1; a_data = 32'h0;
      tick();
      chk("a_seedonly_0", a_od, 32'h0000_0000);
      tick();
      chk("a_seedonly_1", a_od, 32'h03FF_FF80);

      // reset mid-stream with a valid beat
      a_data = $urandom; a_rst = 0;
      tick();
      chk("a_midrst_valid", a_ov, 0);
      chk("a_midrst_data", a_od, 0);
      chk("a_midrst_locked", a_ol, 0);
      a_rst = 1; a_data = 32'h0;
      tick();
      chk("a_postrst_valid", a_ov, 1);
      chk("a_postrst0", a_od, 32'h0000_0000);
      tick();
      chk("a_postrst1", a_od, 32'h03FF_FF80);
      a_valid = 0;

      // ---- loopback W64 ----
      for (int t = 0; t < 1000; t++) begin
         b_valid = 1; b_data = {$urandom, $urandom};
         ref_beat(1, 64, 0, b_data, e);
         orig_q.push_back(b_data);
         tick();
         chk("b_scr_model", b_od, e);
         if (t >= 1) begin
            chk("c_valid", c_ov, 1);
            chk("c_loop_data", c_od, orig_q[t-1]);
            chk("c_locked", c_ol, (t - 1 >= 1) ? 1 : 0);
         end
      end
      b_valid = 0;
      tick();
      chk("c_loop_last", c_od, orig_q[999]);
      chk("c_locked_last", c_ol, 1);

      // ---- descrambler W16: lock after 4 beats ----
      d_cnt = 0;
      d_valid = 1;
      for (int i = 0; i < 8; i++) begin
         d_data = 16'($urandom);
         ref_beat(2, 16, 1, 64'(d_data), e);
         tick();
         chk("d_data", d_od, e);
         chk("d_lock_plain", d_ol, (i >= 4) ? 1 : 0);
      end

      // restart and delay lock with a bypass beat
      d_valid = 0; d_seed = 1;
      tick();
      d_seed = 0; model_reset(2);
      d_valid = 1;
      for (int i = 0; i < 9; i++) begin
         d_data = 16'($urandom);
         if (i == 1) begin
            d_byp = 1; e = 64'(d_data);
         end else begin
            d_byp = 0;
            ref_beat(2, 16, 1, 64'(d_data), e);
         end
         tick();
         chk("d_byp_data", d_od, e);
         chk("d_lock_delayed", d_ol, (i >= 5) ? 1 : 0);
      end
      d_byp = 0;

      // idle on descrambler
      last = e;
      d_valid = 0;
      tick();
      chk("d_idle_valid", d_ov, 0);
      chk("d_idle_hold", d_od, last);
      chk("d_idle_lock", d_ol, 1);

      // seed load with a valid beat on the descrambler
      d_valid = 1; d_seed = 1; d_data = 16'($urandom);
      ref_beat(2, 16, 1, 64'(d_data), e);
      model_reset(2);
      tick();
      chk("d_seed_same_beat", d_od, e);
      d_seed = 0; x = 16'($urandom); d_data = x;
      ref_beat(2, 16, 1, 64'(x), e2);
      tick();
      chk("d_seed_next", d_od, e2);
      chk("d_seed_lock_drop", d_ol, 0);
      d_valid = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
